// File: rtl/tensor_core_pkg.sv
// -----------------------------------------------------------------------------
// tensor_core_pkg
// Shared definitions for the tensor-core host sequencer: instruction opcode and
// opselect fields, fixed NOP/CLEAR instruction words, register-file base
// addresses and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package tensor_core_pkg;

  // Instruction opcode field, bits [1:0].
  localparam logic [1:0] OPC_GENERIC        = 2'b00;
  localparam logic [1:0] OPC_LOAD_IMMEDIATE = 2'b01;
  localparam logic [1:0] OPC_OPERATE        = 2'b10;
  localparam logic [1:0] OPC_BURST          = 2'b11;

  // Opselect field, bits [4:2], for GENERIC instructions.
  localparam logic [2:0] OPSEL_READ  = 3'b000;
  localparam logic [2:0] OPSEL_MOVE  = 3'b001;
  localparam logic [2:0] OPSEL_NOP   = 3'b010;
  localparam logic [2:0] OPSEL_RESET = 3'b011;

  // Fixed instruction words.
  localparam logic [15:0] INSTR_NOP   = {11'b0, OPSEL_NOP,   OPC_GENERIC};  // 16'h0008
  localparam logic [15:0] INSTR_CLEAR = {11'b0, OPSEL_RESET, OPC_GENERIC};  // 16'h000C

  // Register map: matrix1 at 0..8, matrix2 at 9..17, results read back from 0..8.
  localparam logic [4:0] MATRIX1_BASE = 5'd0;
  localparam logic [4:0] MATRIX2_BASE = 5'd9;
  localparam logic [4:0] RESULT_BASE  = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_OPERATE,
    S_WAIT,
    S_READ,
    S_RESP
  } seq_state_e;

endpackage

// File: rtl/tensor_core_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tensor_core_instruction_encoder
// Pure combinational formatter for the parameterised cpu instruction words.
// Ports:
//   load_addr_in / load_data_in -> load_word_out    (LOAD immediate)
//   opsel_in                    -> operate_word_out (OPERATE)
//   read_addr_in                -> read_word_out    (READ register)
// -----------------------------------------------------------------------------
module tensor_core_instruction_encoder
  import tensor_core_pkg::*;
(
  input  logic [4:0]  load_addr_in,
  input  logic [7:0]  load_data_in,
  input  logic [2:0]  opsel_in,
  input  logic [4:0]  read_addr_in,
  output logic [15:0] load_word_out,
  output logic [15:0] operate_word_out,
  output logic [15:0] read_word_out
);

  // Bit 2 is zero for LOAD so the low three bits read 3'b001.
  assign load_word_out    = {load_addr_in, load_data_in, 1'b0, OPC_LOAD_IMMEDIATE};
  assign operate_word_out = {11'b0, opsel_in, OPC_OPERATE};
  // Bit 5 plus the READ opselect make up the four zero bits under the address.
  assign read_word_out    = {5'b0, read_addr_in, 1'b0, OPSEL_READ, OPC_GENERIC};

endmodule

// File: rtl/tensor_core_sequencer.sv
// -----------------------------------------------------------------------------
// tensor_core_sequencer
// Host-side initiator for the tensor-core cpu. Collects 18 operand bytes,
// issues CLEAR, 18 LOADs, one OPERATE, a fixed run of NOPs, then nine READs,
// returning each captured cpu_output byte on a result stream.
// Ports:
//   clock_in, reset_n_in           clock / async active-low reset
//   start_in, operation_select_in  run request and opselect (latched at start)
//   operand_valid_in/_data_in/_ready_out  operand byte stream (sink)
//   instruction_out                registered instruction to the cpu
//   cpu_output_in                  cpu read data
//   result_valid_out/_data_out/result_ready_in  result byte stream (source)
//   busy_out, done_out             status; done pulses after the last result
// -----------------------------------------------------------------------------
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int BUS_WIDTH       = 8,
  parameter int WAIT_CYCLES     = 5,  // must be >= 5 for the cpu to finish
  parameter int MATRIX_ELEMENTS = 9
) (
  input  logic                 clock_in,
  input  logic                 reset_n_in,
  input  logic                 start_in,
  input  logic [2:0]           operation_select_in,
  input  logic                 operand_valid_in,
  input  logic [BUS_WIDTH-1:0] operand_data_in,
  output logic                 operand_ready_out,
  output logic [15:0]          instruction_out,
  input  logic [BUS_WIDTH-1:0] cpu_output_in,
  output logic                 result_valid_out,
  output logic [BUS_WIDTH-1:0] result_data_out,
  input  logic                 result_ready_in,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int         WAIT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [4:0] LAST_LOAD = 5'(2 * MATRIX_ELEMENTS - 1);
  localparam logic [4:0] LAST_READ = 5'(MATRIX_ELEMENTS - 1);

  seq_state_e           state_q,     state_d;
  logic [2:0]           opsel_q,     opsel_d;
  logic [4:0]           load_idx_q,  load_idx_d;
  logic [4:0]           read_idx_q,  read_idx_d;
  logic [WAIT_W-1:0]    wait_cnt_q,  wait_cnt_d;
  logic [15:0]          instr_q,     instr_d;
  logic                 ready_q,     ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [BUS_WIDTH-1:0] res_data_q,  res_data_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;

  logic [4:0]  read_idx_next;
  logic [15:0] load_word, operate_word, read_word;

  // Index of the READ about to be issued: first one after WAIT, next one after RESP.
  assign read_idx_next = (state_q == S_RESP) ? read_idx_q + 5'd1 : 5'd0;

  tensor_core_instruction_encoder u_encoder (
    .load_addr_in     (MATRIX1_BASE + load_idx_q),
    .load_data_in     (operand_data_in),
    .opsel_in         (opsel_q),
    .read_addr_in     (RESULT_BASE + read_idx_next),
    .load_word_out    (load_word),
    .operate_word_out (operate_word),
    .read_word_out    (read_word)
  );

  // Instruction words are chosen for the state being entered, so the cpu sees
  // each one during the cycle the sequencer spends in that state; LOAD is the
  // exception and follows its operand handshake by one cycle.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    opsel_d     = opsel_q;
    load_idx_d  = load_idx_q;
    read_idx_d  = read_idx_q;
    wait_cnt_d  = wait_cnt_q;
    instr_d     = INSTR_NOP;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          opsel_d    = operation_select_in;
          load_idx_d = 5'd0;
          instr_d    = INSTR_CLEAR;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (operand_valid_in && ready_q) begin
          instr_d    = load_word;
          load_idx_d = load_idx_q + 5'd1;
          if (load_idx_q == LAST_LOAD) state_d = S_OPERATE;
        end
      end
      S_OPERATE: begin
        instr_d    = operate_word;
        wait_cnt_d = WAIT_W'(WAIT_CYCLES);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // First WAIT cycle shows OPERATE; the following WAIT_CYCLES show NOP.
        if (wait_cnt_q == '0) begin
          read_idx_d = read_idx_next;
          instr_d    = read_word;
          state_d    = S_READ;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_READ: begin
        res_data_d  = cpu_output_in;
        res_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (result_ready_in) begin
          res_valid_d = 1'b0;
          if (read_idx_q == LAST_READ) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            read_idx_d = read_idx_next;
            instr_d    = read_word;
            state_d    = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= S_IDLE;
      opsel_q     <= '0;
      load_idx_q  <= '0;
      read_idx_q  <= '0;
      wait_cnt_q  <= '0;
      instr_q     <= INSTR_NOP;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q     <= state_d;
      opsel_q     <= opsel_d;
      load_idx_q  <= load_idx_d;
      read_idx_q  <= read_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_q     <= instr_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign instruction_out   = instr_q;
  assign operand_ready_out = ready_q;
  assign result_valid_out  = res_valid_q;
  assign result_data_out   = res_data_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tensor_core_sequencer
// Drives operand/result streams around tensor_core_sequencer, emulates the cpu
// from the instructions it receives, and compares the instruction trace and
// result stream against expectations derived from the operand lists.
// -----------------------------------------------------------------------------
module tb_tensor_core_sequencer;

  localparam int          WAIT_CYCLES = 5;
  localparam logic [15:0] NOP_W       = 16'h0008;
  localparam logic [15:0] CLEAR_W     = 16'h000C;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic [2:0]  operation_select_in;
  logic        operand_valid_in;
  logic [7:0]  operand_data_in;
  logic        operand_ready_out;
  logic [15:0] instruction_out;
  logic [7:0]  cpu_output;
  logic        result_valid_out;
  logic [7:0]  result_data_out;
  logic        result_ready_in;
  logic        busy_out;
  logic        done_out;

  always #5 clock_in = ~clock_in;

  tensor_core_sequencer #(
    .BUS_WIDTH       (8),
    .WAIT_CYCLES     (WAIT_CYCLES),
    .MATRIX_ELEMENTS (9)
  ) dut (
    .clock_in            (clock_in),
    .reset_n_in          (reset_n_in),
    .start_in            (start_in),
    .operation_select_in (operation_select_in),
    .operand_valid_in    (operand_valid_in),
    .operand_data_in     (operand_data_in),
    .operand_ready_out   (operand_ready_out),
    .instruction_out     (instruction_out),
    .cpu_output_in       (cpu_output),
    .result_valid_out    (result_valid_out),
    .result_data_out     (result_data_out),
    .result_ready_in     (result_ready_in),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Operation the stand-in cpu performs; m holds matrix1 at 0..8, matrix2 at 9..17.
  function automatic logic [7:0] op_elem(input logic [2:0] sel, input logic [7:0] m [32],
                                         input int idx);
    int i;
    int j;
    int acc;
    i   = idx / 3;
    j   = idx % 3;
    acc = 0;
    case (sel)
      3'd0:    for (int k = 0; k < 3; k++)
                 acc += int'($signed(m[3*i+k])) * int'($signed(m[9+3*k+j]));
      3'd1:    acc = int'($signed(m[idx])) + int'($signed(m[9+idx]));
      3'd2:    acc = int'($signed(m[idx])) - int'($signed(m[9+idx]));
      default: acc = int'($signed(m[idx])) * int'($signed(m[9+idx]));
    endcase
    return acc[7:0];
  endfunction

  // Stand-in cpu: acts on the instruction present at each rising edge,
  // reads are combinational from the register file.
  logic [7:0] cpu_regs [32];
  always @(posedge clock_in) begin
    if (instruction_out == CLEAR_W) begin
      for (int k = 0; k < 32; k++) cpu_regs[k] <= 8'h00;
    end else if (instruction_out[1:0] == 2'b01) begin
      cpu_regs[instruction_out[15:11]] <= instruction_out[10:3];
    end else if (instruction_out[1:0] == 2'b10) begin
      for (int r = 0; r < 9; r++) cpu_regs[r] <= op_elem(instruction_out[4:2], cpu_regs, r);
    end
  end

  always_comb begin
    cpu_output = 8'h5A;
    if (instruction_out[1:0] == 2'b00 && instruction_out[5:2] == 4'b0000)
      cpu_output = cpu_regs[instruction_out[10:6]];
  end

  // Per-cycle trace of the instruction bus plus a running done-pulse count.
  logic [15:0] instr_log [$];
  int          done_cnt = 0;
  always @(negedge clock_in) begin
    instr_log.push_back(instruction_out);
    if (done_out) done_cnt <= done_cnt + 1;
  end

  logic [7:0]  ops [18];
  logic [7:0]  exp_res [9];
  logic [15:0] exp_instr [$];
  int          runs_done = 0;
  int          sgn_vals [18] = '{-128, 127, -1, 5, -5, 64, -64, 100, -100,
                                 0, 1, 0, -1, 2, -1, -1, 28, -28};

  task automatic build_expect(input logic [2:0] sel);
    logic [7:0] m [32];
    for (int k = 0; k < 32; k++) m[k] = 8'h00;
    for (int k = 0; k < 18; k++) m[k] = ops[k];
    for (int r = 0; r < 9; r++) exp_res[r] = op_elem(sel, m, r);
    exp_instr.delete();
    exp_instr.push_back(CLEAR_W);
    for (int k = 0; k < 18; k++)
      exp_instr.push_back((16'(k) << 11) | (16'(ops[k]) << 3) | 16'h0001);
    exp_instr.push_back((16'(sel) << 2) | 16'h0002);
    for (int r = 0; r < 9; r++) exp_instr.push_back(16'(r) << 6);
  endtask

  task automatic send_operands(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int gap;
      int budget;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      if (gap > 0) operand_valid_in = 1'b0;
      repeat (gap) begin @(posedge clock_in); #1; end
      operand_data_in  = ops[k];
      operand_valid_in = 1'b1;
      budget = 0;
      @(negedge clock_in);
      while (!operand_ready_out && budget < 600) begin
        @(negedge clock_in);
        budget++;
      end
      if (!operand_ready_out) begin
        check("operand_ready_timeout", operand_ready_out, 1);
        operand_valid_in = 1'b0;
        return;
      end
      @(posedge clock_in); #1;
    end
    operand_valid_in = 1'b0;
  endtask

  task automatic collect_results(input string name, input int stall_idx, input int stall_len,
                                 input int max_delay);
    for (int r = 0; r < 9; r++) begin
      int budget;
      int delay;
      budget = 0;
      @(negedge clock_in);
      while (!result_valid_out && budget < 600) begin
        @(negedge clock_in);
        budget++;
      end
      check($sformatf("%s.result_valid%0d", name, r), result_valid_out, 1);
      if (!result_valid_out) return;
      delay = (r == stall_idx) ? stall_len
            : (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
      repeat (delay) begin
        @(negedge clock_in);
        if (r == stall_idx) begin
          check($sformatf("%s.hold_valid", name), result_valid_out, 1);
          check($sformatf("%s.hold_data", name), result_data_out, exp_res[r]);
          check($sformatf("%s.hold_instr", name), instruction_out, NOP_W);
        end
      end
      check($sformatf("%s.result%0d", name, r), result_data_out, exp_res[r]);
      result_ready_in = 1'b1;
      @(posedge clock_in); #1;
      result_ready_in = 1'b0;
    end
    @(negedge clock_in);
    check($sformatf("%s.done_pulse", name), done_out, 1);
    check($sformatf("%s.busy_idle", name), busy_out, 0);
  endtask

  task automatic do_run(input string name, input logic [2:0] sel, input int max_gap,
                        input int stall_idx, input int stall_len, input int max_delay,
                        input bit hold_start);
    int nn;
    int op_pos;
    int rd_pos;
    build_expect(sel);
    check($sformatf("%s.done_total_before", name), done_cnt, runs_done);
    operation_select_in = sel;
    start_in = 1'b1;
    @(posedge clock_in); #1;
    if (!hold_start) start_in = 1'b0;
    fork
      send_operands(18, max_gap);
      collect_results(name, stall_idx, stall_len, max_delay);
    join
    runs_done++;
    // Every non-NOP cycle of the trace must match the expected sequence in order.
    nn = 0;
    op_pos = -1;
    rd_pos = -1;
    for (int c = 0; c < instr_log.size(); c++) begin
      if (instr_log[c] != NOP_W) begin
        if (nn < exp_instr.size())
          check($sformatf("%s.instr%0d", name, nn), instr_log[c], exp_instr[nn]);
        else
          check($sformatf("%s.extra_instr", name), instr_log[c], NOP_W);
        if (op_pos < 0 && instr_log[c][1:0] == 2'b10) op_pos = c;
        else if (op_pos >= 0 && rd_pos < 0 && instr_log[c][1:0] == 2'b00) rd_pos = c;
        nn++;
      end
    end
    check($sformatf("%s.instr_count", name), nn, exp_instr.size());
    check($sformatf("%s.wait_nops", name), rd_pos - op_pos - 1, WAIT_CYCLES);
    instr_log.delete();
    @(negedge clock_in);
    check($sformatf("%s.done_one_cycle", name), done_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n_in          = 1'b0;
    start_in            = 1'b0;
    operation_select_in = 3'd0;
    operand_valid_in    = 1'b0;
    operand_data_in     = 8'h00;
    result_ready_in     = 1'b0;

    repeat (2) @(negedge clock_in);
    check("rst.instr", instruction_out, NOP_W);
    check("rst.ready", operand_ready_out, 0);
    check("rst.valid", result_valid_out, 0);
    check("rst.data", result_data_out, 0);
    check("rst.busy", busy_out, 0);
    check("rst.done", done_out, 0);
    reset_n_in = 1'b1;
    @(negedge clock_in);

    // Abandon a run after five operand bytes.
    for (int k = 0; k < 18; k++) ops[k] = 8'($urandom);
    operation_select_in = 3'd0;
    start_in = 1'b1;
    @(posedge clock_in); #1;
    start_in = 1'b0;
    send_operands(5, 0);
    check("midrst.busy_before", busy_out, 1);
    reset_n_in = 1'b0;
    #1;
    check("midrst.instr", instruction_out, NOP_W);
    check("midrst.ready", operand_ready_out, 0);
    check("midrst.busy", busy_out, 0);
    repeat (3) begin
      @(negedge clock_in);
      check("midrst.instr_hold", instruction_out, NOP_W);
    end
    reset_n_in = 1'b1;
    @(negedge clock_in);
    instr_log.delete();

    // Identity x B with matrix product.
    for (int k = 0; k < 9; k++) ops[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
    for (int k = 0; k < 9; k++) ops[9+k] = 8'(k + 1);
    do_run("ident", 3'd0, 0, -1, 0, 0, 1'b0);

    // Signed extremes through the element-wise add.
    for (int k = 0; k < 18; k++) ops[k] = 8'(sgn_vals[k]);
    do_run("signed", 3'd1, 0, -1, 0, 1, 1'b0);

    // Operand gaps plus a long result stall on result 4.
    for (int k = 0; k < 18; k++) ops[k] = 8'($urandom);
    do_run("gaps", 3'($urandom_range(3, 0)), 10, 4, 7, 2, 1'b0);

    for (int k = 0; k < 18; k++) ops[k] = 8'($urandom);
    do_run("rand", 3'($urandom_range(7, 0)), 4, -1, 0, 3, 1'b0);

    // start_in held high across two back-to-back runs with the same opselect.
    for (int k = 0; k < 18; k++) ops[k] = 8'($urandom);
    do_run("held1", 3'd2, 3, -1, 0, 1, 1'b1);
    for (int k = 0; k < 18; k++) ops[k] = 8'($urandom);
    do_run("held2", 3'd2, 3, -1, 0, 1, 1'b0);

    repeat (4) @(negedge clock_in);
    check("final.done_total", done_cnt, runs_done);
    check("final.busy", busy_out, 0);
    check("final.instr", instruction_out, NOP_W);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tensor_core_sequencer.md
Name: tensor_core_sequencer

Overview:
- Host-side initiator that drives the tensor-core CPU's 16-bit instruction bus and captures its 8-bit signed output.
- Accepts 18 operand bytes on a valid/ready stream and runs one matrix operation end to end: clear, immediate loads, operate, fixed wait, register reads.
- Returns 9 result bytes on a second valid/ready stream.
- Sits between the testbench/host interface and the cpu instance; it is the producer of current_instruction and the consumer of cpu_output.

Parameters:
- BUS_WIDTH, 8, data width of operand/result bytes and of the cpu output.
- WAIT_CYCLES, 5, NOP cycles issued after the OPERATE instruction before the first read; must be ≥5.
- MATRIX_ELEMENTS, 9, elements per matrix (3x3).

Ports:
- clock_in, input, 1, single clock shared with the cpu.
- reset_n_in, input, 1, asynchronous active-low reset.
- start_in, input, 1, begins a run when sampled high in IDLE.
- operation_select_in, input, 3, opselect placed in OPERATE bits [4:2]; latched at start.
- operand_valid_in, input, 1, operand byte valid.
- operand_data_in, input, 8, operand byte, signed.
- operand_ready_out, output, 1, sequencer accepts operand byte.
- instruction_out, output, 16, registered instruction to the cpu current_instruction.
- cpu_output_in, input, 8, cpu_output, signed.
- result_valid_out, output, 1, result byte valid.
- result_data_out, output, 8, result byte.
- result_ready_in, input, 1, consumer accepts result.
- busy_out, output, 1, high in every state except IDLE.
- done_out, output, 1, one-cycle pulse after the 9th result handshake.

Behaviour:
Encodings (instruction_out):
- NOP = 16'h0008.
- CLEAR = 16'h000C.
- LOAD = {addr[4:0], data[7:0], 3'b001}.
- OPERATE = {11'b0, opsel[2:0], 2'b10}.
- READ = {5'b0, addr[4:0], 4'b0000, 2'b00}.

Register map:
- Matrix1 element (i,j) → address 3i+j (0..8).
- Matrix2 element (i,j) → address 9+3i+j (9..17).
- Operand bytes arrive row-major, matrix1 first.
- Results are read from addresses 0..8 in order.

Reset (async, reset_n_in=0):
- State IDLE, instruction_out=NOP, operand_ready_out=0, result_valid_out=0, result_data_out=0, busy_out=0, done_out=0, all counters 0.
- Reset mid-run abandons the run with no further instructions; the next run clears the cpu via CLEAR.

States:
- IDLE: instruction_out=NOP. start_in=1 → latch opsel, go to CLEAR.
- CLEAR: one cycle issuing CLEAR → LOAD.
- LOAD: operand_ready_out=1.
  - On each handshake, next cycle instruction_out=LOAD(idx, byte) for exactly one cycle and idx increments.
  - With no handshake, instruction_out=NOP.
  - After the handshake for idx=17 → OPERATE.
  - operand_ready_out is 0 in every other state.
- OPERATE: exactly one cycle of the OPERATE instruction (a second consecutive OPERATE restarts the cpu timer and is forbidden) → WAIT.
- WAIT: WAIT_CYCLES cycles of NOP, down-counter → READ with ridx=0.
- READ: one cycle issuing READ(ridx). At the closing edge, result_data_out ← cpu_output_in and result_valid_out ← 1 → RESP.
- RESP: instruction_out=NOP; hold result_valid_out/result_data_out stable until result_ready_in.
  - On handshake: result_valid_out=0.
  - If ridx=8: done_out=1 for one cycle → IDLE.
  - Else: ridx++ → READ.

Boundary rules:
- start_in is ignored while busy_out=1.
- Operand stalls and result back-pressure of any length are legal; the cpu sees only NOPs during stalls.
- Signed values pass through unmodified; no arithmetic in this block.
- All outputs are registered; no combinational path from cpu_output_in to any output.

Decomposition:
- Shared package tensor_core_pkg:
  - opcode/opselect constants (GENERIC 2'b00, LOAD_IMMEDIATE 2'b01, OPERATE 2'b10, BURST 2'b11; READ/MOVE/NOP/RESET opselects).
  - NOP/CLEAR instruction constants.
  - Matrix-base address constants.
  - State enum.
- One natural sub-module: tensor_core_instruction_encoder, a pure function/module forming LOAD/OPERATE/READ words; state machine stays in the top.

Test Plan:
- Reset mid-LOAD (after 5 bytes), then a new run → instruction_out=NOP during reset; the new run starts with CLEAR 16'h000C and loads from address 0.
- Identity × B, opsel=3'b000: operands 1,0,0,0,1,0,0,0,1 then 1..9, no stalls → instruction sequence:
  - CLEAR;
  - 18 LOADs, e.g. first 16'h0009, 10th = {5'd9, 8'd1, 3'b001};
  - OPERATE 16'h0002;
  - 5 NOPs;
  - READs;
  - results stream 1..9 (with cpu model), done_out pulses once.
- Signed operands (-128, 127, -1) with opsel=3'b001 → LOAD data fields 8'h80, 8'h7F, 8'hFF exactly; results match the cpu's element-wise reference model.
- Random operand_valid_in gaps (up to 10 cycles) → only NOPs between LOADs; each LOAD issued exactly once and in order; one OPERATE cycle.
- result_ready_in low for 7 cycles on result 4 → result_valid_out/result_data_out stable; instruction_out=NOP; no extra READ issued.
- start_in held high throughout a run → exactly one run; a second run begins only after done_out, from IDLE.
